// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Captures the decoded control word, operands, immediate, PC and register
// specifiers. Detects load-use hazards, inserts bubbles, freezes on
// downstream hold and squashes on an EX redirect.
// Optional: define ID_EX_PERF_CNT_EN to add bubble/flush perf counters.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] id_ctrl,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          ex_redirect,
  input  logic          mem_hold,
  output logic [CW-1:0] ex_ctrl,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_dst,
  output logic          ex_valid,
  output logic          stall_id,
  output logic [1:0]    bubble_cnt
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [15:0]   perf_bubbles,
  output logic [15:0]   perf_flushes
`endif
);

  typedef enum logic {
    ST_RUN,
    ST_BUBBLE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ctrl_q;
  logic [DW-1:0] pc_q, rs_data_q, rt_data_q, imm_q;
  logic [RW-1:0] rs_q, rt_q, dst_q;
  logic          valid_q;
  logic [1:0]    bubble_cnt_q, bubble_cnt_d;

  logic          lu_haz;
  logic          do_flush, do_hold, do_bubble, do_capture;
  logic [RW-1:0] id_dst;

  // Load-use hazard: a load in EX writing a register ID is about to read.
  always_comb begin
    lu_haz = valid_q & ctrl_q[9] & (dst_q != '0) &
             ((dst_q == id_rs) | (dst_q == id_rt));
  end

  // Edge action select: redirect > hold > load-use bubble > capture.
  always_comb begin
    do_flush   = ex_redirect;
    do_hold    = ~ex_redirect & mem_hold;
    do_bubble  = ~ex_redirect & ~mem_hold & lu_haz;
    do_capture = ~ex_redirect & ~mem_hold & ~lu_haz;
    id_dst     = id_ctrl[1] ? id_rd : id_rt;
    stall_id   = (lu_haz | mem_hold) & ~ex_redirect & ~reset;
  end

  // Next state and bubble counter.
  always_comb begin
    state_d      = state_q;
    bubble_cnt_d = bubble_cnt_q;
    if (do_flush) begin
      state_d      = ST_RUN;
      bubble_cnt_d = '0;
    end else if (do_bubble) begin
      state_d      = ST_BUBBLE;
      bubble_cnt_d = (bubble_cnt_q == 2'd3) ? 2'd3 : bubble_cnt_q + 2'd1;
    end else if (do_capture) begin
      state_d      = ST_RUN;
      bubble_cnt_d = '0;
    end
  end

  // Pipeline register and FSM state; a bubble or squash zeroes every field.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      ctrl_q       <= '0;
      pc_q         <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      dst_q        <= '0;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
    end else if (!do_hold) begin
      state_q      <= state_d;
      bubble_cnt_q <= bubble_cnt_d;
      if (do_capture) begin
        ctrl_q    <= id_ctrl;
        pc_q      <= id_pc;
        rs_data_q <= id_rs_data;
        rt_data_q <= id_rt_data;
        imm_q     <= id_imm;
        rs_q      <= id_rs;
        rt_q      <= id_rt;
        dst_q     <= id_dst;
        valid_q   <= 1'b1;
      end else begin
        ctrl_q    <= '0;
        pc_q      <= '0;
        rs_data_q <= '0;
        rt_data_q <= '0;
        imm_q     <= '0;
        rs_q      <= '0;
        rt_q      <= '0;
        dst_q     <= '0;
        valid_q   <= 1'b0;
      end
    end
  end

  assign ex_ctrl    = ctrl_q;
  assign ex_pc      = pc_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_dst     = dst_q;
  assign ex_valid   = valid_q;
  assign bubble_cnt = bubble_cnt_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] perf_bubbles_q, perf_flushes_q;

  // Saturating counters of load-use bubbles and useful-work squashes.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bubbles_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (do_bubble && perf_bubbles_q != '1)
        perf_bubbles_q <= perf_bubbles_q + 16'd1;
      if (do_flush && (valid_q || id_ctrl != '0) && perf_flushes_q != '1)
        perf_flushes_q <= perf_flushes_q + 16'd1;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a behavioural model of the EX slot
// checked every cycle, plus directed vectors with literal expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  id_ctrl;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_redirect, mem_hold;
  logic [9:0]  ex_ctrl;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic        ex_valid, stall_id;
  logic [1:0]  bubble_cnt;
`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] perf_bubbles, perf_flushes;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .RW(5), .CW(10)) dut (
    .clk(clk), .reset(reset),
    .id_ctrl(id_ctrl), .id_pc(id_pc), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_redirect(ex_redirect), .mem_hold(mem_hold),
    .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_valid(ex_valid), .stall_id(stall_id), .bubble_cnt(bubble_cnt)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: the instruction (or nothing) sitting in EX.
  typedef struct {
    logic [9:0]  ctrl;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, dst;
    logic        valid;
  } slot_t;

  slot_t m;
  int    m_bcnt = 0;
  int    m_pb = 0;
  int    m_pf = 0;
  bit    started = 0;

  function automatic slot_t empty_slot();
    slot_t s;
    s.ctrl = '0; s.pc = '0; s.rsd = '0; s.rtd = '0; s.imm = '0;
    s.rs = '0; s.rt = '0; s.dst = '0; s.valid = 1'b0;
    return s;
  endfunction

  function automatic bit model_haz();
    return m.valid && m.ctrl[9] && m.dst != 0 && (m.dst == id_rs || m.dst == id_rt);
  endfunction

  function automatic bit model_stall();
    return (model_haz() || mem_hold) && !ex_redirect && !reset;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m = empty_slot(); m_bcnt = 0; m_pb = 0; m_pf = 0; started = 1;
    end else if (ex_redirect) begin
      if (m.valid || id_ctrl != 0) m_pf = (m_pf < 65535) ? m_pf + 1 : m_pf;
      m = empty_slot(); m_bcnt = 0;
    end else if (mem_hold) begin
      // EX frozen
    end else if (model_haz()) begin
      m = empty_slot();
      m_bcnt = (m_bcnt < 3) ? m_bcnt + 1 : 3;
      m_pb = (m_pb < 65535) ? m_pb + 1 : m_pb;
    end else begin
      m.ctrl = id_ctrl; m.pc = id_pc; m.rsd = id_rs_data; m.rtd = id_rt_data;
      m.imm = id_imm; m.rs = id_rs; m.rt = id_rt;
      m.dst = id_ctrl[1] ? id_rd : id_rt; m.valid = 1'b1; m_bcnt = 0;
    end
  end

  // Compare process: inputs are stable mid-cycle, so check on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("ex_ctrl", 32'(ex_ctrl), 32'(m.ctrl));
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rs_data", ex_rs_data, m.rsd);
      chk("ex_rt_data", ex_rt_data, m.rtd);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_rs", 32'(ex_rs), 32'(m.rs));
      chk("ex_rt", 32'(ex_rt), 32'(m.rt));
      chk("ex_dst", 32'(ex_dst), 32'(m.dst));
      chk("ex_valid", 32'(ex_valid), 32'(m.valid));
      chk("bubble_cnt", 32'(bubble_cnt), 32'(m_bcnt));
      chk("stall_id", 32'(stall_id), 32'(model_stall()));
`ifdef ID_EX_PERF_CNT_EN
      chk("perf_bubbles", 32'(perf_bubbles), 32'(m_pb));
      chk("perf_flushes", 32'(perf_flushes), 32'(m_pf));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [9:0] c, input logic [31:0] pc,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_ctrl = c; id_pc = pc;
    id_rs_data = 32'h1000_0000 | pc; id_rt_data = 32'h2000_0000 | pc;
    id_imm = 32'hFFFF_0000 | pc;
    id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  initial begin
    reset = 1'b1; ex_redirect = 1'b0; mem_hold = 1'b0;
    set_id(10'h3FF, 32'hDEAD_BEEF, 5'd9, 5'd10, 5'd11);
    tick(); tick();
    chk("rst_ctrl", 32'(ex_ctrl), 32'h0);
    chk("rst_valid", 32'(ex_valid), 32'h0);
    chk("rst_stall", 32'(stall_id), 32'h0);

    // First capture after reset release: addi, reg_dst=0 -> dst=rt
    reset = 1'b0;
    set_id(10'h084, 32'h4, 5'd1, 5'd2, 5'd3);
    tick();
    chk("cap_ctrl", 32'(ex_ctrl), 32'h084);
    chk("cap_valid", 32'(ex_valid), 32'h1);
    chk("cap_dst", 32'(ex_dst), 32'd2);
    chk("cap_pc", ex_pc, 32'h4);

    // Load-use: lw r5, then consumer reading r5
    set_id(10'h280, 32'h8, 5'd1, 5'd5, 5'd0);
    tick();
    set_id(10'h086, 32'hC, 5'd5, 5'd6, 5'd7);
    #1 chk("lu_stall", 32'(stall_id), 32'h1);
    tick();
    chk("lu_bub_ctrl", 32'(ex_ctrl), 32'h0);
    chk("lu_bub_valid", 32'(ex_valid), 32'h0);
    chk("lu_bub_cnt", 32'(bubble_cnt), 32'd1);
    chk("lu_after_stall", 32'(stall_id), 32'h0);
    tick();
    chk("lu_cap_ctrl", 32'(ex_ctrl), 32'h086);
    chk("lu_cap_dst", 32'(ex_dst), 32'd7);
    chk("lu_cap_cnt", 32'(bubble_cnt), 32'd0);

    // Load to r0 never hazards
    set_id(10'h280, 32'h10, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(10'h084, 32'h14, 5'd0, 5'd0, 5'd4);
    #1 chk("r0_nostall", 32'(stall_id), 32'h0);
    tick();
    chk("r0_cap", ex_pc, 32'h14);
    // Non-load producer never hazards
    set_id(10'h084, 32'h18, 5'd1, 5'd5, 5'd0);
    tick();
    set_id(10'h084, 32'h1C, 5'd5, 5'd5, 5'd0);
    #1 chk("alu_nostall", 32'(stall_id), 32'h0);
    tick();
    chk("alu_cap", ex_pc, 32'h1C);

    // Redirect beats hold and hazard
    set_id(10'h280, 32'h20, 5'd1, 5'd5, 5'd0);
    tick();
    set_id(10'h084, 32'h24, 5'd5, 5'd2, 5'd0);
    mem_hold = 1'b1; ex_redirect = 1'b1;
    #1 chk("redir_stall", 32'(stall_id), 32'h0);
    tick();
    chk("redir_ctrl", 32'(ex_ctrl), 32'h0);
    chk("redir_valid", 32'(ex_valid), 32'h0);
    mem_hold = 1'b0; ex_redirect = 1'b0;

    // Hold for 3 cycles while ID changes
    set_id(10'h0C4, 32'h100, 5'd1, 5'd2, 5'd3);
    tick();
    mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(10'h084, 32'h200 + 32'(i * 4), 5'd7, 5'd8, 5'd9);
      #1 chk("hold_stall", 32'(stall_id), 32'h1);
      tick();
      chk("hold_pc", ex_pc, 32'h100);
      chk("hold_ctrl", 32'(ex_ctrl), 32'h0C4);
    end
    mem_hold = 1'b0;
    tick();
    chk("release_pc", ex_pc, 32'h208);

    // Hazard under hold: hold wins, no bubble counted
    set_id(10'h280, 32'h300, 5'd1, 5'd5, 5'd0);
    tick();
    set_id(10'h084, 32'h304, 5'd5, 5'd2, 5'd0);
    mem_hold = 1'b1;
    #1 chk("hh_stall", 32'(stall_id), 32'h1);
    tick();
    chk("hh_ctrl", 32'(ex_ctrl), 32'h280);
    chk("hh_cnt", 32'(bubble_cnt), 32'd0);
    mem_hold = 1'b0;
    tick();
    chk("hh_bub_cnt", 32'(bubble_cnt), 32'd1);
    tick();
    chk("hh_cap", ex_pc, 32'h304);

    // Third load-use event, then a redirect with a valid ID slot
    set_id(10'h280, 32'h400, 5'd1, 5'd6, 5'd0);
    tick();
    set_id(10'h084, 32'h404, 5'd2, 5'd6, 5'd0);
    tick();
    tick();
    ex_redirect = 1'b1;
    tick();
    ex_redirect = 1'b0;
    // Redirect with empty EX and empty ID does not count as a flush
    set_id(10'h000, 32'h0, 5'd0, 5'd0, 5'd0);
    ex_redirect = 1'b1;
    tick();
    ex_redirect = 1'b0;
    tick();
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_bubbles_lit", 32'(perf_bubbles), 32'd3);
    chk("perf_flushes_lit", 32'(perf_flushes), 32'd2);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
